bmf_h_stream_decoder: RTL and testbench
=======================================

Name: bmf_h_stream_decoder

Overview:
- Streaming decompressor for Boolean-matrix-factorized approximate sub-circuits: expands a K-bit latent code into an M-bit output vector using a runtime-loadable K x M basis matrix H.
- Sits downstream of a compressor (W-side) stage. Replaces a fixed hard-wired H stage in FPGA/emulation error-characterization runs.
- Accumulates Hamming error against a supplied exact vector.

Parameters:
- K, 3, latent code width (rows of H)
- M, 4, output vector width (columns of H)
- CW, 16, width of the saturating statistics counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  basis row write strobe
- cfg_row  in  $clog2(K)  row index to write
- cfg_data  in  M  row contents
- xor_mode  in  1  0 = OR semiring (Boolean product), 1 = GF(2) XOR; sampled only in CFG state
- run_en  in  1  request decode mode
- in_valid  in  1  code valid
- in_ready  out  1  decoder can accept a code
- in_code  in  K  latent code
- in_exact  in  M  exact reference vector travelling with the code
- out_valid  out  1  output vector valid
- out_ready  in  1  downstream accepts
- out_vec  out  M  decoded vector
- stat_clr  in  1  synchronous clear of the statistics counters
- err_bits  out  CW  saturating sum of popcount(out_vec ^ exact)
- samples  out  CW  saturating count of output handshakes
- cfg_err  out  1  sticky: cfg_we seen outside CFG, or cfg_row >= K
- state_run  out  1  high in RUN

Behaviour:
- Reset values:
  - H = 0, row_written mask = 0, mode = OR
  - state CFG
  - in_ready = 0, out_valid = 0, out_vec = 0
  - err_bits = samples = 0, cfg_err = 0, state_run = 0
- States:
  - CFG: cfg_we with cfg_row < K writes H[cfg_row] and sets its row_written bit. mode latches xor_mode every cycle. in_ready = 0.
  - CFG -> RUN: when run_en = 1 and row_written is all ones. Takes effect the next cycle.
  - RUN: in_ready = !buffer_full. A code is accepted on in_valid & in_ready. If run_en drops, go to DRAIN.
  - DRAIN: in_ready = 0. When the buffer is empty, go to CFG. row_written is retained, so a re-entry to RUN needs no reload.
- Decode:
  - vec = fold over i in 0..K-1 of (in_code[i] ? H[i] : 0), folded with OR or XOR per mode.
  - vec is computed combinationally at acceptance and registered into a 2-entry output FIFO together with in_exact.
- Latency and throughput:
  - A code accepted at cycle t gives out_valid at t+1 at the earliest.
  - Sustained 1 vector/cycle while out_ready = 1.
  - in_ready is registered: no combinational path from out_ready.
- Output handshake:
  - out_vec is held stable while out_valid & !out_ready.
  - Entries leave in order.
  - Simultaneous push and pop on a full FIFO is not allowed, because in_ready = 0 when full.
  - Simultaneous push and pop on a 1-entry FIFO keeps the count at 1.
- Statistics:
  - On each out_valid & out_ready: samples += 1 and err_bits += popcount(out_vec ^ exact).
  - Both saturate at 2^CW-1 and never wrap.
  - stat_clr has priority over an update in the same cycle; the result is 0.
- cfg_err:
  - Set by cfg_we in RUN/DRAIN (the write is ignored) or by cfg_row >= K (the write is ignored).
  - Cleared only by rst.
- Reset mid-operation: the FIFO is flushed, out_valid drops the next cycle, and H is lost.

Decomposition:
- Shared package bmf_pkg:
  - state enum {CFG, RUN, DRAIN}
  - mode constants MODE_OR / MODE_XOR
  - popcount function
  - saturating add function
- One sub-module: bmf_fifo2, a 2-entry valid/ready buffer of width 2*M, with a registered not-full output.

Test Plan:
- Load H0=0001, H1=0100, H2=1000 in OR mode, then run. Codes 101, 010, 111 -> out_vec 1001, 0100, 1101, each one cycle after acceptance.
- Load H0=0011, H1=0110, H2=0000. Code 011 gives 0111 in OR mode and 0101 in XOR mode. Confirm that changing xor_mode during RUN has no effect.
- Backpressure:
  - out_ready=0 with in_valid=1: exactly 2 codes accepted, then in_ready=0.
  - Raising out_ready drains the vectors in order with no loss or duplication.
- Statistics:
  - Exact vector 1111 with out_vec 1001 for 3 samples -> err_bits=6, samples=3.
  - stat_clr in the same cycle as a handshake -> both 0.
  - Preload near saturation -> the counters stick at 65535.
- Configuration and mode transitions:
  - run_en=1 with only 2 of 3 rows written -> stays in CFG, in_ready=0.
  - cfg_we during RUN -> H unchanged, cfg_err=1.
  - run_en dropped with 2 entries pending -> both entries delivered, then CFG.
- rst asserted while the FIFO is full -> next cycle out_valid=0, state CFG, counters 0, and out_vec for code 111 = 0000 after re-entering RUN without reload (blocked, since row_written was cleared).

Source files
------------

// File: rtl/bmf_pkg.sv
// Shared types and helpers for the BMF H-side stream decoder.
// Helpers work on 32-bit values so one definition serves any M/CW up to 32.
package bmf_pkg;

  typedef enum logic [1:0] {
    CFG   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic MODE_OR  = 1'b0;
  localparam logic MODE_XOR = 1'b1;

  function automatic logic [31:0] popcount(input logic [31:0] v);
    logic [31:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 32'(v[i]);
    return c;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, max}) return max;
    return s[31:0];
  endfunction

endpackage

// File: rtl/bmf_fifo2.sv
// Two-entry in-order valid/ready buffer; not_full is a flop so the upstream
// ready never depends combinationally on the downstream pop.
module bmf_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         not_full,
  input  logic         pop,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic [1:0]   count_q, count_d, cnt_after_pop;
  logic [W-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic         not_full_q, not_full_d;
  logic         do_push, do_pop;

  always_comb begin
    do_push       = push && (count_q != 2'd2);
    do_pop        = pop && (count_q != 2'd0);
    mem0_d        = mem0_q;
    mem1_d        = mem1_q;
    cnt_after_pop = count_q - {1'b0, do_pop};
    if (do_pop) mem0_d = mem1_q;
    if (do_push) begin
      if (cnt_after_pop == 2'd0) mem0_d = din;
      else                       mem1_d = din;
    end
    count_d    = cnt_after_pop + {1'b0, do_push};
    not_full_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      mem0_q     <= '0;
      mem1_q     <= '0;
      not_full_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
      not_full_q <= not_full_d;
    end
  end

  assign not_full = not_full_q;
  assign valid    = (count_q != 2'd0);
  assign dout     = mem0_q;

endmodule

// File: rtl/bmf_h_stream_decoder.sv
// Expands K-bit latent codes through a loadable K x M basis H (OR or XOR fold)
// and tracks Hamming error of the decoded vectors against a reference.
module bmf_h_stream_decoder
  import bmf_pkg::*;
#(
  parameter int K  = 3,
  parameter int M  = 4,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [$clog2(K)-1:0] cfg_row,
  input  logic [M-1:0]         cfg_data,
  input  logic                 xor_mode,
  input  logic                 run_en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K-1:0]         in_code,
  input  logic [M-1:0]         in_exact,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [M-1:0]         out_vec,
  input  logic                 stat_clr,
  output logic [CW-1:0]        err_bits,
  output logic [CW-1:0]        samples,
  output logic                 cfg_err,
  output logic                 state_run
);

  localparam logic [31:0] SAT_MAX = 32'((64'd1 << CW) - 64'd1);

  state_e              state_q, state_d;
  logic [K-1:0][M-1:0] h_q, h_d;
  logic [K-1:0]        rw_q, rw_d;
  logic                mode_q, mode_d;
  logic                cfg_err_q, cfg_err_d;
  logic [CW-1:0]       err_q, err_d, samp_q, samp_d;
  logic [M-1:0]        vec, exact_out;
  logic [2*M-1:0]      fifo_dout;
  logic                fifo_nf, fifo_valid, push, hs;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= CFG;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG:     if (run_en && (&rw_q)) state_d = RUN;
      RUN:     if (!run_en) state_d = DRAIN;
      DRAIN:   if (!fifo_valid) state_d = CFG;
      default: state_d = CFG;
    endcase
  end

  // state outputs
  always_comb begin
    in_ready  = 1'b0;
    state_run = 1'b0;
    if (state_q == RUN) begin
      in_ready  = fifo_nf;
      state_run = 1'b1;
    end
  end

  always_comb begin
    h_d       = h_q;
    rw_d      = rw_q;
    mode_d    = mode_q;
    cfg_err_d = cfg_err_q;
    if (state_q == CFG) mode_d = xor_mode;
    if (cfg_we) begin
      if ((state_q != CFG) || (int'(cfg_row) >= K)) begin
        cfg_err_d = 1'b1;
      end else begin
        h_d[cfg_row]  = cfg_data;
        rw_d[cfg_row] = 1'b1;
      end
    end
  end

  always_comb begin
    vec = '0;
    for (int i = 0; i < K; i++) begin
      if (in_code[i]) vec = (mode_q == MODE_XOR) ? (vec ^ h_q[i]) : (vec | h_q[i]);
    end
  end

  assign push = in_valid && in_ready;
  assign hs   = fifo_valid && out_ready;

  bmf_fifo2 #(.W(2 * M)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      ({in_exact, vec}),
    .not_full (fifo_nf),
    .pop      (out_ready),
    .valid    (fifo_valid),
    .dout     (fifo_dout)
  );

  assign out_vec   = fifo_dout[M-1:0];
  assign exact_out = fifo_dout[2*M-1:M];
  assign out_valid = fifo_valid;

  // clear wins over a same-cycle update
  always_comb begin
    err_d  = err_q;
    samp_d = samp_q;
    if (stat_clr) begin
      err_d  = '0;
      samp_d = '0;
    end else if (hs) begin
      err_d  = CW'(sat_add(32'(err_q), popcount(32'(out_vec ^ exact_out)), SAT_MAX));
      samp_d = CW'(sat_add(32'(samp_q), 32'd1, SAT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q       <= '0;
      rw_q      <= '0;
      mode_q    <= MODE_OR;
      cfg_err_q <= 1'b0;
      err_q     <= '0;
      samp_q    <= '0;
    end else begin
      h_q       <= h_d;
      rw_q      <= rw_d;
      mode_q    <= mode_d;
      cfg_err_q <= cfg_err_d;
      err_q     <= err_d;
      samp_q    <= samp_d;
    end
  end

  assign err_bits = err_q;
  assign samples  = samp_q;
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_bmf_h_stream_decoder.sv
// Scoreboard bench for bmf_h_stream_decoder: expected vectors are queued at
// acceptance from a reference fold over the bench's own copy of H.
module tb_bmf_h_stream_decoder;

  localparam int K  = 3;
  localparam int M  = 4;
  localparam int CW = 16;
  localparam int SATV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst, cfg_we, xor_mode, run_en, in_valid, out_ready, stat_clr;
  logic [$clog2(K)-1:0] cfg_row;
  logic [M-1:0] cfg_data, in_exact, out_vec;
  logic [K-1:0] in_code;
  logic in_ready, out_valid, cfg_err, state_run;
  logic [CW-1:0] err_bits, samples;

  always #5 clk = ~clk;

  bmf_h_stream_decoder #(.K(K), .M(M), .CW(CW)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
    .xor_mode(xor_mode), .run_en(run_en), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_exact(in_exact), .out_valid(out_valid), .out_ready(out_ready),
    .out_vec(out_vec), .stat_clr(stat_clr), .err_bits(err_bits), .samples(samples),
    .cfg_err(cfg_err), .state_run(state_run)
  );

  int checks = 0;
  int errors = 0;
  logic [2*M-1:0] sbq[$];
  logic [M-1:0] m_h[K];
  logic m_mode;
  int m_err, m_samp;

  function automatic logic [M-1:0] model_vec(input logic [K-1:0] code);
    logic [M-1:0] v;
    v = '0;
    for (int i = 0; i < K; i++)
      if (code[i]) v = m_mode ? (v ^ m_h[i]) : (v | m_h[i]);
    return v;
  endfunction

  function automatic int pc(input logic [M-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < M; i++) c += int'(v[i]);
    return c;
  endfunction

  // One clock: score the handshakes visible now, then advance past the edge.
  task automatic tick();
    logic acc, hs;
    logic [2*M-1:0] e;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    if (hs) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_output got %h want none", out_vec);
      end else begin
        e = sbq.pop_front();
        if (out_vec !== e[M-1:0]) begin
          errors++;
          $display("FAIL sb_out_vec got %h want %h", out_vec, e[M-1:0]);
        end
        if (m_samp < SATV) m_samp++;
        m_err = (m_err + pc(e[M-1:0] ^ e[2*M-1:M]) > SATV) ? SATV : m_err + pc(e[M-1:0] ^ e[2*M-1:M]);
      end
    end
    if (stat_clr) begin
      m_err  = 0;
      m_samp = 0;
    end
    if (acc) sbq.push_back({in_exact, model_vec(in_code)});
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [$clog2(K)-1:0] r, input logic [M-1:0] d, input bit takes);
    cfg_we = 1'b1; cfg_row = r; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    if (takes && int'(r) < K) m_h[r] = d;
  endtask

  task automatic enter_run();
    run_en = 1'b1;
    m_mode = xor_mode;
    for (int i = 0; i < 4 && !state_run; i++) tick();
    checks++;
    if (state_run !== 1'b1) begin errors++; $display("FAIL enter_run got %b want 1", state_run); end
  endtask

  task automatic leave_run();
    run_en = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && (out_valid || state_run); i++) tick();
    checks++;
    if (out_valid || state_run) begin errors++; $display("FAIL leave_run_timeout got %b%b want 00", out_valid, state_run); end
    tick(); tick();
  endtask

  task automatic send_code(input logic [K-1:0] c, input logic [M-1:0] ex);
    in_valid = 1'b1; in_code = c; in_exact = ex;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL send_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_out_valid got %b want 1", out_valid); end
  endtask

  task automatic drain_queue();
    for (int i = 0; i < 10 && sbq.size() != 0; i++) tick();
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL drain_timeout got %0d want 0", sbq.size()); end
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (out_vec !== 4'h0) begin errors++; $display("FAIL rst_out_vec got %h want 0", out_vec); end
    checks++; if (err_bits !== '0) begin errors++; $display("FAIL rst_err_bits got %0d want 0", err_bits); end
    checks++; if (samples !== '0) begin errors++; $display("FAIL rst_samples got %0d want 0", samples); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_cfg_err got %b want 0", cfg_err); end
    checks++; if (state_run !== 1'b0) begin errors++; $display("FAIL rst_state_run got %b want 0", state_run); end
  endtask

  task automatic test_or_decode();
    xor_mode = 1'b0;
    write_row(2'd0, 4'b0001, 1);
    write_row(2'd1, 4'b0100, 1);
    run_en = 1'b1;
    tick(); tick(); tick();
    checks++; if (state_run !== 1'b0) begin errors++; $display("FAIL partial_rows_run got %b want 0", state_run); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL partial_rows_ready got %b want 0", in_ready); end
    run_en = 1'b0;
    write_row(2'd2, 4'b1000, 1);
    enter_run();
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    out_ready = 1'b1; in_exact = 4'b1111; in_code = 3'b101; in_valid = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_vec !== 4'b1001) begin errors++; $display("FAIL or_101 got %b%h want 1 9", out_valid, out_vec); end
    tick(); tick();
    in_valid = 1'b0;
    tick();
    checks++; if (err_bits !== 16'd6) begin errors++; $display("FAIL stat_err_bits got %0d want 6", err_bits); end
    checks++; if (samples !== 16'd3) begin errors++; $display("FAIL stat_samples got %0d want 3", samples); end
    send_code(3'b010, 4'b1111);
    checks++; if (out_vec !== 4'b0100) begin errors++; $display("FAIL or_010 got %h want 4", out_vec); end
    send_code(3'b111, 4'b1111);
    checks++; if (out_vec !== 4'b1101) begin errors++; $display("FAIL or_111 got %h want d", out_vec); end
    tick();
    checks++; if (err_bits !== CW'(m_err) || samples !== CW'(m_samp)) begin errors++; $display("FAIL stat_model got %0d/%0d want %0d/%0d", err_bits, samples, m_err, m_samp); end
  endtask

  task automatic test_stat_clr();
    send_code(3'b101, 4'b1111);
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    checks++; if (err_bits !== '0 || samples !== '0) begin errors++; $display("FAIL stat_clr_prio got %0d/%0d want 0/0", err_bits, samples); end
  endtask

  task automatic test_xor();
    leave_run();
    xor_mode = 1'b0;
    write_row(2'd0, 4'b0011, 1);
    write_row(2'd1, 4'b0110, 1);
    write_row(2'd2, 4'b0000, 1);
    enter_run();
    send_code(3'b011, 4'b0000);
    checks++; if (out_vec !== 4'b0111) begin errors++; $display("FAIL or_011 got %h want 7", out_vec); end
    tick();
    leave_run();
    xor_mode = 1'b1;
    enter_run();
    send_code(3'b011, 4'b0000);
    checks++; if (out_vec !== 4'b0101) begin errors++; $display("FAIL xor_011 got %h want 5", out_vec); end
    tick();
    xor_mode = 1'b0;
    tick(); tick();
    send_code(3'b011, 4'b0000);
    checks++; if (out_vec !== 4'b0101) begin errors++; $display("FAIL xor_mode_in_run got %h want 5", out_vec); end
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_code = 3'(i + 1); in_exact = 4'(i);
      if (in_ready) n++;
      tick();
    end
    in_valid = 1'b0;
    checks++; if (n != 2) begin errors++; $display("FAIL bp_accepts got %0d want 2", n); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
    checks++; if (out_vec !== 4'b0011) begin errors++; $display("FAIL bp_hold got %h want 3", out_vec); end
    out_ready = 1'b1;
    drain_queue();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b want 0", out_valid); end
  endtask

  task automatic test_cfg_run_write();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err_pre got %b want 0", cfg_err); end
    write_row(2'd0, 4'b1111, 0);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_run_we got %b want 1", cfg_err); end
    send_code(3'b001, 4'b0000);
    checks++; if (out_vec !== 4'b0011) begin errors++; $display("FAIL h_unchanged got %h want 3", out_vec); end
    tick();
  endtask

  task automatic test_drain();
    out_ready = 1'b0; in_valid = 1'b1; in_exact = 4'b1010;
    in_code = 3'b001; tick();
    in_code = 3'b010; tick();
    in_valid = 1'b0; run_en = 1'b0;
    tick(); tick();
    checks++; if (state_run !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL drain_hold got %b%b want 01", state_run, out_valid); end
    out_ready = 1'b1;
    drain_queue();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", out_valid); end
    enter_run();
  endtask

  task automatic test_saturation();
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_code = 3'b000; in_exact = 4'b1111;
    for (int i = 0; i < 65540; i++) tick();
    in_valid = 1'b0;
    tick();
    checks++; if (samples !== 16'hFFFF) begin errors++; $display("FAIL sat_samples got %0d want 65535", samples); end
    checks++; if (err_bits !== 16'hFFFF) begin errors++; $display("FAIL sat_err_bits got %0d want 65535", err_bits); end
    checks++; if (err_bits !== CW'(m_err) || samples !== CW'(m_samp)) begin errors++; $display("FAIL sat_model got %0d/%0d want %0d/%0d", err_bits, samples, m_err, m_samp); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_code = 3'b111; in_exact = 4'b0000;
    tick(); tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL pre_rst_full got %b%b want 10", out_valid, in_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    for (int i = 0; i < K; i++) m_h[i] = '0;
    m_err = 0; m_samp = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    checks++; if (state_run !== 1'b0) begin errors++; $display("FAIL mid_rst_state got %b want 0", state_run); end
    checks++; if (err_bits !== '0 || samples !== '0) begin errors++; $display("FAIL mid_rst_counters got %0d/%0d want 0/0", err_bits, samples); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL mid_rst_cfg_err got %b want 0", cfg_err); end
    run_en = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (state_run !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rerun_blocked got %b%b want 00", state_run, in_ready); end
    in_valid = 1'b1; in_code = 3'b111;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_vec !== 4'h0) begin errors++; $display("FAIL rerun_out got %b%h want 0 0", out_valid, out_vec); end
    run_en = 1'b0;
    write_row(2'd3, 4'b1111, 1);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL cfg_err_row_range got %b want 1", cfg_err); end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_row = '0; cfg_data = '0; xor_mode = 1'b0;
    run_en = 1'b0; in_valid = 1'b0; in_code = '0; in_exact = '0; out_ready = 1'b0; stat_clr = 1'b0;
    for (int i = 0; i < K; i++) m_h[i] = '0;
    m_mode = 1'b0; m_err = 0; m_samp = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_or_decode();
    test_stat_clr();
    test_xor();
    test_backpressure();
    test_cfg_run_write();
    test_drain();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
